traffic_light_nway: RTL and testbench

Parametrised successor to the two-way intersection controller. It drives NUM_DIR approaches with round-robin service of latched car requests, and splits each change of right-of-way into yellow and all-red clearance. Green time is sensor-actuated: a minimum green, extended up to a maximum while the approach's own sensor stays occupied. A two-digit seven-segment countdown shows the seconds remaining in the current phase. The block sits at board top level, fed by slide-switch sensors, and drives LEDs and HEX displays.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/traffic_light_nway_tick.sv | 32 +++
 rtl/traffic_light_nway.sv | 191 +++++++++++++++++++
 tb/tb_traffic_light_nway.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`timescale 1ns/1ps
// traffic_pkg
// Shared definitions for the N-way traffic light controller:
//   phase_t - right-of-way phase of the active approach
//   LED_*   - per-approach lamp codes, {red,yellow,green}, one-hot
//   seg7()  - BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  localparam logic [2:0] LED_G = 3'b001;
  localparam logic [2:0] LED_Y = 3'b010;
  localparam logic [2:0] LED_R = 3'b100;

  // Elapsed-seconds counter and countdown both saturate at this value.
  localparam logic [6:0] SEC_SAT = 7'd99;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/traffic_light_nway_tick.sv
`timescale 1ns/1ps
// sec_tick_gen
// Free-running prescaler producing a one-cycle tick every CNT_MAX clocks.
//   CLOCK_50 - system clock
//   RESET    - asynchronous, active-high reset (count returns to 0)
//   tick     - high for exactly one cycle while the count equals CNT_MAX-1
module sec_tick_gen #(
  parameter int unsigned CNT_MAX = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  output logic tick
);

  localparam int unsigned W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_light_nway.sv
`timescale 1ns/1ps
// traffic_light_nway
// Round-robin, sensor-actuated controller for NUM_DIR approaches with
// yellow and all-red clearance and a two-digit seven-segment countdown.
//   CLOCK_50 - system clock
//   RESET    - asynchronous, active-high reset
//   SW       - car sensor per approach (level, synchronous)
//   LED      - per approach i: LED[3i+2:3i] = {red,yellow,green}, one-hot
//   ACTIVE   - index of the approach owning right-of-way
//   HEX0     - countdown ones digit, active-low {g,f,e,d,c,b,a}
//   HEX1     - countdown tens digit, same encoding (0 is shown, not blanked)
module traffic_light_nway
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR   = 4,
  parameter int unsigned CNT_MAX   = 50_000_000,
  parameter int unsigned GREEN_MIN = 30,
  parameter int unsigned GREEN_MAX = 60,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic [NUM_DIR-1:0]         SW,
  output logic [3*NUM_DIR-1:0]       LED,
  output logic [$clog2(NUM_DIR)-1:0] ACTIVE,
  output logic [6:0]                 HEX0,
  output logic [6:0]                 HEX1
);

  localparam int unsigned AW = $clog2(NUM_DIR);

  logic          tick;

  phase_t        phase_q, phase_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] nxt_q, nxt_d;
  logic [6:0]    sec_q, sec_d;
  logic [NUM_DIR-1:0] req_q, req_d;

  logic [AW-1:0] sel;
  logic          pend;
  logic [7:0]    e;
  logic [6:0]    sec_inc;
  logic          enter_green;

  logic [3*NUM_DIR-1:0] led_d;
  logic [6:0]           cd;
  logic [6:0]           hex0_d, hex1_d;

  sec_tick_gen #(
    .CNT_MAX (CNT_MAX)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .tick     (tick)
  );

  // Round-robin pick: walk from the farthest successor back to the nearest
  // so the nearest pending approach after cur overwrites the others.
  always_comb begin
    int unsigned idx;
    idx  = 0;
    sel  = cur_q;
    pend = 1'b0;
    for (int unsigned k = NUM_DIR - 1; k >= 1; k--) begin
      idx = (32'(cur_q) + k) % NUM_DIR;
      if (req_q[AW'(idx)]) begin
        sel  = AW'(idx);
        pend = 1'b1;
      end
    end
  end

  // Phase sequencing; every change happens on a tick only.
  always_comb begin
    phase_d     = phase_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    sec_d       = sec_q;
    enter_green = 1'b0;
    e           = {1'b0, sec_q} + 8'd1;
    sec_inc     = (e > {1'b0, SEC_SAT}) ? SEC_SAT : e[6:0];

    if (tick) begin
      sec_d = sec_inc;
      case (phase_q)
        PH_GREEN: begin
          if (pend && ((e >= 8'(GREEN_MIN) && !SW[cur_q]) || e >= 8'(GREEN_MAX))) begin
            phase_d = PH_YELLOW;
            nxt_d   = sel;
            sec_d   = '0;
          end
        end
        PH_YELLOW: begin
          if (e == 8'(YELLOW_T)) begin
            phase_d = PH_ALLRED;
            sec_d   = '0;
          end
        end
        PH_ALLRED: begin
          if (e == 8'(ALLRED_T)) begin
            phase_d     = PH_GREEN;
            cur_d       = nxt_q;
            sec_d       = '0;
            enter_green = 1'b1;
          end
        end
        default: begin
          phase_d = PH_GREEN;
          sec_d   = '0;
        end
      endcase
    end
  end

  // Request latches: the green approach ignores its own sensor, and the
  // clear on green entry is applied last so it wins over a same-cycle set.
  always_comb begin
    req_d = req_q;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (SW[i] && !(AW'(i) == cur_q && phase_q == PH_GREEN)) begin
        req_d[i] = 1'b1;
      end
    end
    if (enter_green) begin
      req_d[cur_d] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      phase_q <= PH_GREEN;
      cur_q   <= '0;
      nxt_q   <= '0;
      sec_q   <= '0;
      req_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      sec_q   <= sec_d;
      req_q   <= req_d;
    end
  end

  // Outputs are decoded from the next state so that they change on the
  // same edge as the phase/seconds registers.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      led_d[3*i +: 3] = LED_R;
      if (AW'(i) == cur_d) begin
        case (phase_d)
          PH_GREEN:  led_d[3*i +: 3] = LED_G;
          PH_YELLOW: led_d[3*i +: 3] = LED_Y;
          default:   led_d[3*i +: 3] = LED_R;
        endcase
      end
    end
  end

  always_comb begin
    cd = '0;
    case (phase_d)
      PH_GREEN:  cd = (sec_d >= 7'(GREEN_MIN)) ? '0 : 7'(GREEN_MIN) - sec_d;
      PH_YELLOW: cd = (sec_d >= 7'(YELLOW_T))  ? '0 : 7'(YELLOW_T) - sec_d;
      PH_ALLRED: cd = (sec_d >= 7'(ALLRED_T))  ? '0 : 7'(ALLRED_T) - sec_d;
      default:   cd = '0;
    endcase
    if (cd > SEC_SAT) begin
      cd = SEC_SAT;
    end
    hex1_d = seg7(4'(cd / 7'd10));
    hex0_d = seg7(4'(cd % 7'd10));
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      LED    <= {{(NUM_DIR-1){LED_R}}, LED_G};
      ACTIVE <= '0;
      HEX1   <= seg7(4'(GREEN_MIN / 10));
      HEX0   <= seg7(4'(GREEN_MIN % 10));
    end else begin
      LED    <= led_d;
      ACTIVE <= cur_d;
      HEX1   <= hex1_d;
      HEX0   <= hex0_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_nway.sv
`timescale 1ns/1ps
// tb_traffic_light_nway
// Directed bench for traffic_light_nway with a 5-clock second tick.
// Edge counts are taken from reset release; tick k lands on edge 5k.
module tb_traffic_light_nway;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [3:0]  SW;
  logic [11:0] LED;
  logic [1:0]  ACTIVE;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [11:0] LED_RST = 12'b100_100_100_001;
  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

  int n_cmp  = 0;
  int n_err  = 0;
  int ecount = 0;
  bit green2_seen = 1'b0;

  traffic_light_nway #(
    .NUM_DIR   (4),
    .CNT_MAX   (5),
    .GREEN_MIN (3),
    .GREEN_MAX (6),
    .YELLOW_T  (2),
    .ALLRED_T  (1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .SW       (SW),
    .LED      (LED),
    .ACTIVE   (ACTIVE),
    .HEX0     (HEX0),
    .HEX1     (HEX1)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  task automatic step_to(input int target);
    while (ecount < target) begin
      @(posedge CLOCK_50);
      #1;
      ecount++;
      if (LED[8:6] == 3'b001) green2_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b1;
    SW    = '0;
    #100;
    RESET  = 1'b0;
    ecount = 0;
  endtask

  task automatic pulse(input logic [1:0] idx);
    SW[idx] = 1'b1;
    step_to(ecount + 1);
    SW[idx] = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values, idle countdown
    RESET = 1'b1;
    SW    = '0;
    #95;
    chk("t1_rst_led",    32'(LED),    32'(LED_RST));
    chk("t1_rst_active", 32'(ACTIVE), 32'd0);
    chk("t1_rst_hex1",   32'(HEX1),   32'(SEG[0]));
    chk("t1_rst_hex0",   32'(HEX0),   32'(SEG[3]));
    @(posedge CLOCK_50);
    #1;
    RESET  = 1'b0;
    ecount = 0;
    step_to(4);
    chk("t1_hex0_pre",   32'(HEX0),   32'(SEG[3]));
    step_to(5);
    chk("t1_hex0_t1",    32'(HEX0),   32'(SEG[2]));
    step_to(10);
    chk("t1_hex0_t2",    32'(HEX0),   32'(SEG[1]));
    step_to(15);
    chk("t1_hex0_t3",    32'(HEX0),   32'(SEG[0]));
    step_to(2000);
    chk("t1_idle_led",   32'(LED),    32'(LED_RST));
    chk("t1_idle_act",   32'(ACTIVE), 32'd0);
    chk("t1_idle_hex1",  32'(HEX1),   32'(SEG[0]));
    chk("t1_idle_hex0",  32'(HEX0),   32'(SEG[0]));

    // 2: single request from approach 2
    do_reset();
    pulse(2'd2);
    step_to(14);
    chk("t2_green_hold", 32'(LED[2:0]), 32'b001);
    step_to(15);
    chk("t2_yellow_led", 32'(LED),    32'(12'b100_100_100_010));
    chk("t2_yellow_hex", 32'(HEX0),   32'(SEG[2]));
    step_to(25);
    chk("t2_allred_led", 32'(LED),    32'(ALL_RED));
    chk("t2_allred_hex", 32'(HEX0),   32'(SEG[1]));
    step_to(29);
    chk("t2_allred_hold", 32'(LED),   32'(ALL_RED));
    step_to(30);
    chk("t2_g2_led",     32'(LED),    32'(12'b100_001_100_100));
    chk("t2_g2_active",  32'(ACTIVE), 32'd2);
    chk("t2_g2_hex0",    32'(HEX0),   32'(SEG[3]));
    step_to(300);
    chk("t2_g2_stay",    32'(LED),    32'(12'b100_001_100_100));
    chk("t2_g2_stay_act", 32'(ACTIVE), 32'd2);

    // 3a: own sensor occupied extends green to GREEN_MAX
    do_reset();
    SW[0] = 1'b1;
    pulse(2'd1);
    step_to(29);
    chk("t3a_green_ext", 32'(LED[2:0]), 32'b001);
    step_to(30);
    chk("t3a_yellow_max", 32'(LED[2:0]), 32'b010);
    SW[0] = 1'b0;

    // 3b: own sensor empty, yellow at GREEN_MIN
    do_reset();
    pulse(2'd1);
    step_to(14);
    chk("t3b_green_min", 32'(LED[2:0]), 32'b001);
    step_to(15);
    chk("t3b_yellow_min", 32'(LED[2:0]), 32'b010);

    // 4: round-robin order 1, 3, then 0; approach 2 never served
    do_reset();
    SW[1] = 1'b1;
    SW[3] = 1'b1;
    step_to(1);
    SW = '0;
    green2_seen = 1'b0;
    step_to(30);
    chk("t4_serve1",     32'(ACTIVE),    32'd1);
    chk("t4_serve1_led", 32'(LED[5:3]),  32'b001);
    step_to(45);
    chk("t4_yellow1",    32'(LED[5:3]),  32'b010);
    step_to(60);
    chk("t4_serve3",     32'(ACTIVE),    32'd3);
    chk("t4_serve3_led", 32'(LED[11:9]), 32'b001);
    pulse(2'd0);
    step_to(75);
    chk("t4_yellow3",    32'(LED[11:9]), 32'b010);
    step_to(90);
    chk("t4_serve0",     32'(ACTIVE),    32'd0);
    chk("t4_serve0_led", 32'(LED),       32'(LED_RST));
    chk("t4_no_green2",  32'(green2_seen), 32'd0);

    // 5: asynchronous reset during approach 1 yellow drops pending requests
    do_reset();
    pulse(2'd1);
    step_to(30);
    chk("t5_serve1",     32'(ACTIVE),   32'd1);
    pulse(2'd2);
    step_to(47);
    chk("t5_yellow1",    32'(LED[5:3]), 32'b010);
    RESET = 1'b1;
    #2;
    chk("t5_async_led",  32'(LED),      32'(LED_RST));
    chk("t5_async_act",  32'(ACTIVE),   32'd0);
    chk("t5_async_hex0", 32'(HEX0),     32'(SEG[3]));
    @(posedge CLOCK_50);
    #1;
    RESET  = 1'b0;
    ecount = 0;
    step_to(300);
    chk("t5_idle_led",   32'(LED),      32'(LED_RST));
    chk("t5_idle_act",   32'(ACTIVE),   32'd0);

    // 6: own sensor during green is not latched
    do_reset();
    pulse(2'd3);
    pulse(2'd0);
    step_to(15);
    chk("t6_yellow0",    32'(LED[2:0]), 32'b010);
    step_to(30);
    chk("t6_serve3",     32'(ACTIVE),   32'd3);
    chk("t6_serve3_led", 32'(LED),      32'(12'b001_100_100_100));
    step_to(400);
    chk("t6_stay3",      32'(ACTIVE),   32'd3);
    chk("t6_stay3_led",  32'(LED),      32'(12'b001_100_100_100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
